// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: stage enables, IF/ID flush, ID/EX bubble,
// memory-wait and debug-halt sequencing, and a saturating stall-cycle counter.
module pipe_stall_ctrl #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rm,
  input  logic             br_taken,
  input  logic             mem_busy,
  input  logic             halt_req,
  input  logic             step,
  input  logic             clr_cnt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALTED   = 2'b10
  } state_t;

  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

  state_t state, state_next;
  logic   lu_hazard;
  logic   active;

  assign lu_hazard = ex_mem_read && (ex_rd != ZR) &&
                     ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));

  assign ctrl_state = state;

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_next  = state;
    // Only a halted core without a step pulse is idle; the MEM_WAIT exit cycle advances.
    active      = (state != HALTED) || step;

    if (!reset) begin
      if (mem_busy || !active) begin
        pc_en = 1'b0;
      end else if (lu_hazard) begin
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        idex_bubble = 1'b1;
      end else begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = br_taken;
      end

      case (state)
        RUN: begin
          if (mem_busy)      state_next = MEM_WAIT;
          else if (halt_req) state_next = HALTED;
        end
        MEM_WAIT: begin
          if (!mem_busy) state_next = halt_req ? HALTED : RUN;
        end
        HALTED: begin
          if (mem_busy)       state_next = MEM_WAIT;
          else if (!halt_req) state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr_cnt)
      stall_cycles <= '0;
    else if (!pc_en && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios plus random
// traffic, compared every cycle against a rule-level reference model.
module tb_pipe_stall_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          ex_mem_read;
  logic [4:0]    ex_rd, id_rn, id_rm;
  logic          id_uses_rm, br_taken, mem_busy, halt_req, step, clr_cnt;
  logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble;
  logic [1:0]    ctrl_state;
  logic [CW-1:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  int m_state = 0;
  int m_cnt   = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.REG_W(5), .ZERO_REG(31), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm), .br_taken(br_taken),
    .mem_busy(mem_busy), .halt_req(halt_req), .step(step), .clr_cnt(clr_cnt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .ctrl_state(ctrl_state), .stall_cycles(stall_cycles)
  );

  wire [6:0] ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble};

  // Expected {pc,ifid,idex,exmem,memwb,flush,bubble} from the priority rules.
  function automatic logic [6:0] exp_ctl();
    bit hz;
    hz = ex_mem_read && (ex_rd != 5'd31) &&
         ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));
    if (reset)                          return 7'b0000000;
    if (mem_busy)                       return 7'b0000000;
    if ((m_state == 2) && !step)        return 7'b0000000;
    if (hz)                             return 7'b0011101;
    if (br_taken)                       return 7'b1111110;
    return 7'b1111100;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic half();
    #4;
    check("ctl", int'(ctl), int'(exp_ctl()));
    check("state", int'(ctrl_state), m_state);
    check("count", int'(stall_cycles), m_cnt);
  endtask

  task automatic tick();
    logic [6:0] e;
    e = exp_ctl();
    @(posedge clk);
    if (reset) begin
      m_state = 0;
      m_cnt   = 0;
    end else begin
      m_state = mem_busy ? 1 : (halt_req ? 2 : 0);
      if (clr_cnt)                  m_cnt = 0;
      else if (!e[6] && m_cnt < 15) m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  task automatic cyc();
    half();
    tick();
  endtask

  task automatic idle_in();
    ex_mem_read = 0; ex_rd = 0; id_rn = 1; id_rm = 2; id_uses_rm = 0;
    br_taken = 0; mem_busy = 0; halt_req = 0; step = 0; clr_cnt = 0;
  endtask

  task automatic set_hazard();
    ex_mem_read = 1; ex_rd = 5; id_rn = 5; id_rm = 2; id_uses_rm = 1;
  endtask

  task automatic do_reset();
    reset = 1;
    cyc(); cyc();
    reset = 0;
  endtask

  initial begin
    idle_in();
    reset = 1;
    tick();                       // establish a known register state first

    // T1 reset and release
    do_reset();
    cyc();
    check("t1_state_lit", int'(ctrl_state), 0);
    half();
    check("t1_en_lit", int'(ctl), 7'h7C);
    tick();

    // T2 load-use hazard and its non-hazard variants
    do_reset();
    set_hazard();
    half();
    check("t2_stall_lit", int'(ctl), 7'h1D);
    check("t2_cnt0_lit", int'(stall_cycles), 0);
    tick();
    idle_in();
    half();
    check("t2_cnt1_lit", int'(stall_cycles), 1);
    tick();
    set_hazard(); ex_rd = 31; id_rn = 31;
    half();
    check("t2_xzr_lit", int'(ctl), 7'h7C);
    tick();
    set_hazard(); id_rn = 9; id_rm = 5; id_uses_rm = 0;
    cyc();
    id_uses_rm = 1;
    cyc();

    // T3 branch flush, and branch losing to a hazard
    idle_in(); br_taken = 1;
    half();
    check("t3_flush_lit", int'(ctl), 7'h7E);
    tick();
    set_hazard(); br_taken = 1;
    half();
    check("t3_hz_br_lit", int'(ctl), 7'h1D);
    tick();

    // T4 memory freeze over a hazard
    do_reset();
    set_hazard(); mem_busy = 1;
    repeat (3) cyc();
    mem_busy = 0;
    half();
    check("t4_state_lit", int'(ctrl_state), 1);
    check("t4_cnt_lit", int'(stall_cycles), 3);
    check("t4_bubble_lit", int'(ctl), 7'h1D);
    tick();
    idle_in();
    half();
    check("t4_run_lit", int'(ctrl_state), 0);
    tick();

    // T5 debug halt, single step, step under mem_busy, resume
    halt_req = 1;
    half();
    check("t5_halt_cyc_lit", int'(ctl), 7'h7C);
    tick();
    half();
    check("t5_halted_lit", int'(ctrl_state), 2);
    check("t5_en0_lit", int'(ctl), 7'h00);
    tick();
    step = 1;
    half();
    check("t5_step_lit", int'(ctl), 7'h7C);
    tick();
    step = 0;
    cyc();
    step = 1; mem_busy = 1;
    half();
    check("t5_step_busy_lit", int'(ctl), 7'h00);
    tick();
    step = 0; mem_busy = 0;
    cyc();
    halt_req = 0;
    cyc();
    half();
    check("t5_resume_lit", int'(ctrl_state), 0);
    tick();

    // T6 saturation, then clear beating a same-cycle stall
    do_reset();
    mem_busy = 1;
    repeat (20) cyc();
    half();
    check("t6_sat_lit", int'(stall_cycles), 15);
    tick();
    clr_cnt = 1;
    cyc();
    clr_cnt = 0;
    half();
    check("t6_clr_lit", int'(stall_cycles), 0);
    tick();
    idle_in();
    cyc();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      int pick;
      reset       = ($urandom_range(0, 99) == 0);
      ex_mem_read = ($urandom_range(0, 1) == 1);
      pick        = $urandom_range(0, 3);
      ex_rd       = (pick == 0) ? 5'd31 : (pick == 1) ? 5'd5 : 5'($urandom_range(0, 7));
      id_rn       = 5'($urandom_range(0, 7));
      id_rm       = ($urandom_range(0, 1) == 1) ? 5'd5 : 5'($urandom_range(0, 31));
      id_uses_rm  = ($urandom_range(0, 1) == 1);
      br_taken    = ($urandom_range(0, 3) == 0);
      mem_busy    = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 9) == 0) halt_req = ~halt_req;
      step        = ($urandom_range(0, 2) == 0);
      clr_cnt     = ($urandom_range(0, 29) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
